// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select encoding and default PC register index
// shared by the hazard controller and its tag comparators.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam int PC_REG_DEFAULT = 15;

endpackage

// File: rtl/hazard_ctrl_tag_cmp.sv
// tag_cmp: one source tag against one destination tag, qualified by the
// reader's use bit, the writer's write enable and the never-forwarded PC index.
module tag_cmp
  import hazard_pkg::*;
#(
  parameter int AW     = 4,
  parameter int PC_REG = PC_REG_DEFAULT
) (
  input  logic [AW-1:0] ra,
  input  logic          used,
  input  logic [AW-1:0] wa,
  input  logic          we,
  output logic          match
);

  localparam logic [AW-1:0] PC_TAG = AW'(PC_REG);

  assign match = used & we & (ra == wa) & (ra != PC_TAG);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: shadow tag pipeline, forwarding selects, load-use stalls and
// branch flushes for the F/D/E/M/W datapath. Define FORWARDING_EN for bypassing;
// without it every RAW hazard against E or M interlocks and ForwardE stays 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW     = 4,
  parameter int NRP    = 2,
  parameter int PC_REG = PC_REG_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   RAD,
  input  logic [NRP-1:0]      RAUsedD,
  input  logic [AW-1:0]       WA3D,
  input  logic                RegWriteD,
  input  logic                MemtoRegD,
  input  logic                BranchTakenE,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE,
  output logic [2*NRP-1:0]    ForwardE,
  output logic [NRP-1:0]      MatchEM,
  output logic [NRP-1:0]      MatchEW,
  output logic [CNT_W-1:0]    StallCount
);

`ifdef FORWARDING_EN
  localparam logic RAW_INTERLOCK = 1'b0;
`else
  localparam logic RAW_INTERLOCK = 1'b1;
`endif

  logic                live_q, live_d;
  logic [NRP*AW-1:0]   rae_q, rae_d;
  logic [NRP-1:0]      raused_e_q, raused_e_d;
  logic [AW-1:0]       wa3_e_q, wa3_e_d, wa3_m_q, wa3_m_d, wa3_w_q, wa3_w_d;
  logic                regwrite_e_q, regwrite_e_d;
  logic                memtoreg_e_q, memtoreg_e_d;
  logic                regwrite_m_q, regwrite_m_d;
  logic                regwrite_w_q, regwrite_w_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [NRP-1:0]      match_em, match_ew, hit_e, hit_m;
  logic [2*NRP-1:0]    fwd;
  logic                we_e_hz, we_m_hz, ld_stall, stall_d, flush_e;

  // Outputs stay quiet until the first edge after reset release.
  assign we_e_hz = regwrite_e_q & (memtoreg_e_q | RAW_INTERLOCK);
  assign we_m_hz = regwrite_m_q & RAW_INTERLOCK;

  for (genvar i = 0; i < NRP; i++) begin : g_port
    tag_cmp #(.AW(AW), .PC_REG(PC_REG)) u_em (
      .ra(rae_q[i*AW +: AW]), .used(raused_e_q[i]),
      .wa(wa3_m_q), .we(regwrite_m_q), .match(match_em[i]));
    tag_cmp #(.AW(AW), .PC_REG(PC_REG)) u_ew (
      .ra(rae_q[i*AW +: AW]), .used(raused_e_q[i]),
      .wa(wa3_w_q), .we(regwrite_w_q), .match(match_ew[i]));
    tag_cmp #(.AW(AW), .PC_REG(PC_REG)) u_de (
      .ra(RAD[i*AW +: AW]), .used(RAUsedD[i]),
      .wa(wa3_e_q), .we(we_e_hz), .match(hit_e[i]));
    tag_cmp #(.AW(AW), .PC_REG(PC_REG)) u_dm (
      .ra(RAD[i*AW +: AW]), .used(RAUsedD[i]),
      .wa(wa3_m_q), .we(we_m_hz), .match(hit_m[i]));
  end

  assign ld_stall = |(hit_e | hit_m);
  assign stall_d  = live_q & ld_stall & ~BranchTakenE;
  assign flush_e  = live_q & (ld_stall | BranchTakenE);

  always_comb begin
    fwd = '0;
    for (int i = 0; i < NRP; i++) begin
      if (match_em[i])      fwd[2*i +: 2] = FWD_M;
      else if (match_ew[i]) fwd[2*i +: 2] = FWD_W;
      else                  fwd[2*i +: 2] = FWD_RF;
    end
    if (RAW_INTERLOCK || !live_q) fwd = '0;
  end

  assign StallF     = stall_d;
  assign StallD     = stall_d;
  assign FlushD     = live_q & BranchTakenE;
  assign FlushE     = flush_e;
  assign ForwardE   = fwd;
  assign MatchEM    = match_em & {NRP{live_q}};
  assign MatchEW    = match_ew & {NRP{live_q}};
  assign StallCount = stall_cnt_q;

  always_comb begin
    live_d       = 1'b1;
    rae_d        = RAD;
    raused_e_d   = RAUsedD;
    wa3_e_d      = WA3D;
    regwrite_e_d = RegWriteD;
    memtoreg_e_d = MemtoRegD;
    if (flush_e) begin
      raused_e_d   = '0;
      regwrite_e_d = 1'b0;
      memtoreg_e_d = 1'b0;
    end
    wa3_m_d      = wa3_e_q;
    regwrite_m_d = regwrite_e_q;
    wa3_w_d      = wa3_m_q;
    regwrite_w_d = regwrite_m_q;
    stall_cnt_d  = stall_cnt_q;
    if (stall_d && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q       <= 1'b0;
      rae_q        <= '0;
      raused_e_q   <= '0;
      wa3_e_q      <= '0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      wa3_m_q      <= '0;
      regwrite_m_q <= 1'b0;
      wa3_w_q      <= '0;
      regwrite_w_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      live_q       <= live_d;
      rae_q        <= rae_d;
      raused_e_q   <= raused_e_d;
      wa3_e_q      <= wa3_e_d;
      regwrite_e_q <= regwrite_e_d;
      memtoreg_e_q <= memtoreg_e_d;
      wa3_m_q      <= wa3_m_d;
      regwrite_m_q <= regwrite_m_d;
      wa3_w_q      <= wa3_w_d;
      regwrite_w_q <= regwrite_w_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random instruction streams checked against an
// instruction-level pipeline model of the hazard rules.
module tb_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] ra;
    logic [1:0] used;
    logic [3:0] wa;
    logic       rw;
    logic       ld;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  RAD;
  logic [1:0]  RAUsedD;
  logic [3:0]  WA3D;
  logic        RegWriteD, MemtoRegD, BranchTakenE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [3:0]  ForwardE;
  logic [1:0]  MatchEM, MatchEW;
  logic [15:0] StallCount;

  int          errors = 0;
  int          checks = 0;

  ins_t        me, mm, mw;
  logic        live_m;
  int unsigned cnt_m;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .RAD(RAD), .RAUsedD(RAUsedD), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardE(ForwardE), .MatchEM(MatchEM), .MatchEW(MatchEW),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [3:0] r0, input logic [3:0] r1,
                              input logic [1:0] used, input logic [3:0] wa,
                              input logic rw, input logic ld);
    ins_t t;
    t.ra = {r1, r0}; t.used = used; t.wa = wa; t.rw = rw; t.ld = ld;
    return t;
  endfunction

  function automatic logic [3:0] pick();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic model_reset();
    me = '0; mm = '0; mw = '0; live_m = 1'b0; cnt_m = 0;
  endtask

  // One pipeline cycle: present D and the branch, check at negedge, advance model.
  task automatic step(input ins_t d, input logic br);
    logic [1:0] em, ew;
    logic [3:0] fw, er, dr;
    logic       lds, st, fe;
    RAD = d.ra; RAUsedD = d.used; WA3D = d.wa;
    RegWriteD = d.rw; MemtoRegD = d.ld; BranchTakenE = br;
    em = '0; ew = '0; fw = '0; lds = 1'b0;
    for (int i = 0; i < 2; i++) begin
      er = me.ra[i*4 +: 4];
      dr = d.ra[i*4 +: 4];
      em[i] = live_m && me.used[i] && mm.rw && (er == mm.wa) && (er != 4'd15);
      ew[i] = live_m && me.used[i] && mw.rw && (er == mw.wa) && (er != 4'd15);
      if (FWD) fw[i*2 +: 2] = em[i] ? 2'b10 : (ew[i] ? 2'b01 : 2'b00);
      if (live_m && d.used[i] && (dr != 4'd15)) begin
        if (me.rw && (dr == me.wa) && (me.ld || !FWD)) lds = 1'b1;
        if (!FWD && mm.rw && (dr == mm.wa)) lds = 1'b1;
      end
    end
    st = lds && !br;
    fe = live_m && (lds || br);
    @(negedge clk);
    chk("stall", {StallF, StallD}, {st, st});
    chk("flush", {FlushD, FlushE}, {live_m && br, fe});
    chk("fwd", ForwardE, fw);
    chk("match", {MatchEM, MatchEW}, {em, ew});
    chk("cnt", StallCount, cnt_m);
    @(posedge clk); #1;
    if (st && cnt_m != 32'hFFFF) cnt_m++;
    mw = mm; mm = me;
    me = fe ? '0 : d;
    live_m = 1'b1;
  endtask

  initial begin
    int unsigned c0;
    ins_t nop, dep, r;
    nop = mk(0, 0, 2'b00, 0, 0, 0);
    model_reset();
    reset = 1'b1;
    RAD = 8'h11; RAUsedD = 2'b11; WA3D = 4'd1;
    RegWriteD = 1'b1; MemtoRegD = 1'b1; BranchTakenE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {StallF, StallD, FlushD, FlushE, ForwardE, MatchEM, MatchEW}, 0);
    chk("reset_cnt", StallCount, 0);
    reset = 1'b0;

    // First cycle after release (branch input high) must stay silent.
    step(mk(1, 1, 2'b11, 1, 1, 1), 1'b1);
    step(nop, 1'b0);
    step(nop, 1'b0);

    // Back-to-back ALU dependence, then dependence with one gap.
    step(mk(2, 3, 2'b11, 1, 1, 0), 1'b0);
    step(mk(1, 3, 2'b11, 2, 1, 0), 1'b0);
    step(nop, 1'b0);
    step(nop, 1'b0);
    step(mk(2, 3, 2'b11, 1, 1, 0), 1'b0);
    step(nop, 1'b0);
    step(mk(5, 1, 2'b11, 4, 1, 0), 1'b0);
    step(nop, 1'b0);
    step(nop, 1'b0);

    // Load-use.
    c0 = cnt_m;
    dep = mk(1, 1, 2'b11, 2, 1, 0);
    step(mk(0, 0, 2'b01, 1, 1, 1), 1'b0);
    step(dep, 1'b0);
    step(dep, 1'b0);
    step(dep, 1'b0);
    step(nop, 1'b0);
    step(nop, 1'b0);
    chk("t3_cnt", StallCount, c0 + (FWD ? 1 : 2));

    // Branch in the same cycle as a load-use: no stall, both flushed.
    c0 = cnt_m;
    step(mk(0, 0, 2'b01, 1, 1, 1), 1'b0);
    step(dep, 1'b1);
    step(nop, 1'b0);
    step(nop, 1'b0);
    chk("t4_cnt", StallCount, c0);

    // ALU producer then dependent consumer held in D.
    c0 = cnt_m;
    step(mk(2, 3, 2'b11, 1, 1, 0), 1'b0);
    step(dep, 1'b0);
    step(dep, 1'b0);
    step(dep, 1'b0);
    step(nop, 1'b0);
    step(nop, 1'b0);
    chk("t6_cnt", StallCount, c0 + (FWD ? 0 : 2));

    // PC register is never a hazard.
    c0 = cnt_m;
    step(mk(0, 0, 2'b00, 15, 1, 1), 1'b0);
    step(mk(15, 15, 2'b11, 3, 1, 0), 1'b0);
    step(mk(15, 15, 2'b11, 3, 1, 0), 1'b0);
    step(nop, 1'b0);
    chk("t5_cnt", StallCount, c0);

    // Reset asserted in the middle of a load-use stall.
    step(mk(0, 0, 2'b01, 1, 1, 1), 1'b0);
    RAD = dep.ra; RAUsedD = dep.used; WA3D = dep.wa;
    RegWriteD = dep.rw; MemtoRegD = dep.ld; BranchTakenE = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", {StallD, FlushE}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("midrst_outs", {StallF, StallD, FlushD, FlushE, ForwardE, MatchEM, MatchEW}, 0);
    chk("midrst_cnt", StallCount, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      r.ra   = {pick(), pick()};
      r.used = 2'($urandom_range(0, 3));
      r.wa   = pick();
      r.rw   = 1'($urandom_range(0, 3) != 0);
      r.ld   = r.rw & 1'($urandom_range(0, 1));
      step(r, 1'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
